// File: rtl/maze_tile_renderer.sv
// ---------------------------------------------------------------------------
// maze_tile_renderer
//
// Pixel-colour stage that sits right after the VGA timing generator. It draws
// the 28x31-tile maze as a window of 8x8-pixel tiles. Each tile code comes
// from an external tile-map RAM, and each tile's pixels come from an external
// pattern ROM holding 2 bits per pixel. Tiles carrying PELLET_CODE blink: they
// are shown for BLINK_FRAMES frames, then hidden for BLINK_FRAMES frames.
//
// The pipeline is four edges deep, from input sample to colour:
//   E1  window test, tile-map address, in-tile offsets
//   E2  tile-map RAM read cycle
//   E3  pattern address, pellet/blink decision
//   E4  pixel select, palette, output register
//
// Ports:
//   i_clk_25M         pixel clock
//   i_rst             asynchronous reset, active-high
//   i_show_en         display-time flag from the timing generator
//   i_x_cord [9:0]    screen row    (0..479)
//   i_y_cord [9:0]    screen column (0..639)
//   o_tile_addr [9:0] tile-map RAM address; the RAM answers one cycle later
//   i_tile_data [7:0] tile code from the tile-map RAM
//   o_pat_addr [10:0] pattern ROM address {tile_code, row_in_tile}
//   i_pat_data [15:0] pattern row; column c is at bits [2c+1:2c]
//   o_R/o_G/o_B [7:0] registered pixel colour
//   o_show_en_d       i_show_en delayed to line up with the colour
//   o_frame_tick      one-cycle pulse when the last visible pixel is sampled
// ---------------------------------------------------------------------------
module maze_tile_renderer #(
    parameter int unsigned ORIGIN_ROW   = 116,
    parameter int unsigned ORIGIN_COL   = 208,
    parameter int unsigned MAP_COLS     = 28,
    parameter int unsigned MAP_ROWS     = 31,
    parameter logic [7:0]  PELLET_CODE  = 8'h14,
    parameter int unsigned BLINK_FRAMES = 15
) (
    input  logic        i_clk_25M,
    input  logic        i_rst,
    input  logic        i_show_en,
    input  logic [9:0]  i_x_cord,
    input  logic [9:0]  i_y_cord,
    output logic [9:0]  o_tile_addr,
    input  logic [7:0]  i_tile_data,
    output logic [10:0] o_pat_addr,
    input  logic [15:0] i_pat_data,
    output logic [7:0]  o_R,
    output logic [7:0]  o_G,
    output logic [7:0]  o_B,
    output logic        o_show_en_d,
    output logic        o_frame_tick
);

    localparam int unsigned ROW_END = ORIGIN_ROW + 8 * MAP_ROWS;
    localparam int unsigned COL_END = ORIGIN_COL + 8 * MAP_COLS;
    localparam int unsigned CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    // Pick the 2-bit pixel index for in-tile column c out of a pattern row.
    function automatic logic [1:0] pick_pixel(input logic [15:0] pat,
                                              input logic [2:0]  c);
        return pat[{c, 1'b0} +: 2];
    endfunction

    // Map a 2-bit pixel index to {R,G,B}.
    function automatic logic [23:0] palette(input logic [1:0] p);
        logic [23:0] rgb;
        case (p)
            2'd0:    rgb = {8'd0,   8'd0,   8'd0};
            2'd1:    rgb = {8'd33,  8'd33,  8'd255};
            2'd2:    rgb = {8'd255, 8'd184, 8'd151};
            default: rgb = {8'd255, 8'd255, 8'd255};
        endcase
        return rgb;
    endfunction

    // -----------------------------------------------------------------------
    // E1 combinational: window test and tile-map address
    // -----------------------------------------------------------------------
    logic       row_in_c;
    logic       col_in_c;
    logic       win_c;
    logic       frame_end_c;
    logic [9:0] row_off_c;
    logic [9:0] col_off_c;
    logic [9:0] tile_addr_c;

    always_comb begin
        row_in_c = ({22'd0, i_x_cord} >= ORIGIN_ROW) && ({22'd0, i_x_cord} < ROW_END);
        col_in_c = ({22'd0, i_y_cord} >= ORIGIN_COL) && ({22'd0, i_y_cord} < COL_END);
        win_c    = i_show_en && row_in_c && col_in_c;
        // The offsets are computed only inside the window, so they never
        // wrap. Outside the window they stay at zero, which also forces the
        // tile address to 0.
        row_off_c = '0;
        col_off_c = '0;
        if (win_c) begin
            row_off_c = i_x_cord - 10'(ORIGIN_ROW);
            col_off_c = i_y_cord - 10'(ORIGIN_COL);
        end
        tile_addr_c = {3'd0, row_off_c[9:3]} * 10'(MAP_COLS) + {3'd0, col_off_c[9:3]};
        frame_end_c = i_show_en && (i_x_cord == 10'd479) && (i_y_cord == 10'd639);
    end

    // -----------------------------------------------------------------------
    // Frame counter and blink phase
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] frame_cnt_d;
    logic             blink_vis_q;
    logic             blink_vis_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_vis_d = blink_vis_q;
        if (frame_end_c) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                blink_vis_d = ~blink_vis_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt_q  <= '0;
            blink_vis_q  <= 1'b1;
            o_frame_tick <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            blink_vis_q  <= blink_vis_d;
            o_frame_tick <= frame_end_c;
        end
    end

    // -----------------------------------------------------------------------
    // E1 registers
    // -----------------------------------------------------------------------
    logic       win_p1_q;
    logic       show_p1_q;
    logic       vis_p1_q;
    logic [2:0] row_lo_p1_q;
    logic [2:0] col_lo_p1_q;

    // Each pixel carries the blink phase that was current when it was
    // sampled. The frame-end pixel therefore still sees the old phase, even
    // though the toggle happens on that same edge.
    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst) begin
            win_p1_q    <= 1'b0;
            show_p1_q   <= 1'b0;
            vis_p1_q    <= 1'b1;
            o_tile_addr <= '0;
        end else begin
            win_p1_q    <= win_c;
            show_p1_q   <= i_show_en;
            vis_p1_q    <= blink_vis_q;
            o_tile_addr <= tile_addr_c;
        end
    end

    always_ff @(posedge i_clk_25M) begin
        row_lo_p1_q <= row_off_c[2:0];
        col_lo_p1_q <= col_off_c[2:0];
    end

    // -----------------------------------------------------------------------
    // E2 registers: tile-map RAM read in flight
    // -----------------------------------------------------------------------
    logic       win_p2_q;
    logic       show_p2_q;
    logic       vis_p2_q;
    logic [2:0] row_lo_p2_q;
    logic [2:0] col_lo_p2_q;

    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst) begin
            win_p2_q  <= 1'b0;
            show_p2_q <= 1'b0;
            vis_p2_q  <= 1'b1;
        end else begin
            win_p2_q  <= win_p1_q;
            show_p2_q <= show_p1_q;
            vis_p2_q  <= vis_p1_q;
        end
    end

    always_ff @(posedge i_clk_25M) begin
        row_lo_p2_q <= row_lo_p1_q;
        col_lo_p2_q <= col_lo_p1_q;
    end

    // -----------------------------------------------------------------------
    // E3 registers: pattern address and pellet decision
    // -----------------------------------------------------------------------
    // o_pat_addr doubles as the pattern ROM's address register. i_pat_data
    // is expected to hold this address's row during the next cycle, in time
    // for the E4 edge.
    logic       win_p3_q;
    logic       show_p3_q;
    logic       pellet_p3_q;
    logic [2:0] col_lo_p3_q;

    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst) begin
            win_p3_q    <= 1'b0;
            show_p3_q   <= 1'b0;
            pellet_p3_q <= 1'b0;
            o_pat_addr  <= '0;
        end else begin
            win_p3_q    <= win_p2_q;
            show_p3_q   <= show_p2_q;
            pellet_p3_q <= (i_tile_data == PELLET_CODE) && !vis_p2_q;
            o_pat_addr  <= {i_tile_data, row_lo_p2_q};
        end
    end

    always_ff @(posedge i_clk_25M) begin
        col_lo_p3_q <= col_lo_p2_q;
    end

    // -----------------------------------------------------------------------
    // E4: pixel select, palette, output register
    // -----------------------------------------------------------------------
    logic [23:0] rgb_d;

    always_comb begin
        rgb_d = '0;
        if (win_p3_q && show_p3_q && !pellet_p3_q) begin
            rgb_d = palette(pick_pixel(i_pat_data, col_lo_p3_q));
        end
    end

    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst) begin
            o_R         <= '0;
            o_G         <= '0;
            o_B         <= '0;
            o_show_en_d <= 1'b0;
        end else begin
            o_R         <= rgb_d[23:16];
            o_G         <= rgb_d[15:8];
            o_B         <= rgb_d[7:0];
            o_show_en_d <= show_p3_q;
        end
    end

endmodule

// File: tb/tb_maze_tile_renderer.sv
module tb_maze_tile_renderer;

    localparam int BF  = 2;
    localparam int OR0 = 116;
    localparam int OC0 = 208;
    localparam int NR  = 31;
    localparam int NC  = 28;
    localparam logic [23:0] PEACH = {8'd255, 8'd184, 8'd151};
    localparam logic [23:0] BLUE  = {8'd33, 8'd33, 8'd255};
    localparam logic [23:0] WHITE = {8'd255, 8'd255, 8'd255};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        show = 1'b0;
    logic [9:0]  xc = '0;
    logic [9:0]  yc = '0;
    logic [9:0]  tile_addr;
    logic [7:0]  tile_data = '0;
    logic [10:0] pat_addr;
    logic [15:0] pat_data;
    logic [7:0]  r_o, g_o, b_o;
    logic        show_d;
    logic        tick_o;

    int checks = 0;
    int failures = 0;
    int frames_seen = 0;

    logic [7:0]  tmap [0:1023];
    logic [15:0] prom [0:2047];

    int   seq_show [0:299];
    int   seq_row  [0:299];
    int   seq_col  [0:299];
    logic [24:0] exp_px  [0:299];
    int          exp_addr[0:299];
    int          exp_pat [0:299];
    bit          exp_win [0:299];
    bit          exp_fe  [0:299];
    logic [24:0] obs_px  [0:303];
    logic [9:0]  obs_addr[0:303];
    logic [10:0] obs_pat [0:303];
    logic        obs_tick[0:303];

    maze_tile_renderer #(.BLINK_FRAMES(BF)) dut (
        .i_clk_25M   (clk),
        .i_rst       (rst),
        .i_show_en   (show),
        .i_x_cord    (xc),
        .i_y_cord    (yc),
        .o_tile_addr (tile_addr),
        .i_tile_data (tile_data),
        .o_pat_addr  (pat_addr),
        .i_pat_data  (pat_data),
        .o_R         (r_o),
        .o_G         (g_o),
        .o_B         (b_o),
        .o_show_en_d (show_d),
        .o_frame_tick(tick_o)
    );

    always #5 clk = ~clk;

    // Tile-map RAM: registered read. Pattern ROM: read from the DUT's address register.
    always @(posedge clk) tile_data <= tmap[tile_addr];
    assign pat_data = prom[pat_addr];

    function automatic bit in_win(int s, int r, int c);
        return (s != 0) && r >= OR0 && r < OR0 + 8 * NR && c >= OC0 && c < OC0 + 8 * NC;
    endfunction

    function automatic bit vis_now();
        return ((frames_seen / BF) % 2) == 0;
    endfunction

    function automatic int model_addr(int s, int r, int c);
        if (!in_win(s, r, c)) return 0;
        return ((r - OR0) / 8) * NC + (c - OC0) / 8;
    endfunction

    function automatic logic [24:0] model_px(int s, int r, int c, bit vis);
        int code, pat, p;
        logic [23:0] rgb;
        if (!in_win(s, r, c)) return {(s != 0), 24'h0};
        code = int'(tmap[model_addr(s, r, c)]);
        pat  = int'(prom[code * 8 + (r - OR0) % 8]);
        p    = (pat >> (2 * ((c - OC0) % 8))) & 3;
        case (p)
            0: rgb = 24'h0;
            1: rgb = BLUE;
            2: rgb = PEACH;
            default: rgb = WHITE;
        endcase
        if (code == 8'h14 && !vis) rgb = 24'h0;
        return {1'b1, rgb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives seq_* for n pixels followed by 4 idle cycles, records expected
    // values from the model and the DUT outputs after every edge.
    task automatic run_seq(input int n);
        for (int k = 0; k < n + 4; k++) begin
            if (k < n) begin
                show = (seq_show[k] != 0);
                xc   = 10'(seq_row[k]);
                yc   = 10'(seq_col[k]);
                exp_px[k]   = model_px(seq_show[k], seq_row[k], seq_col[k], vis_now());
                exp_addr[k] = model_addr(seq_show[k], seq_row[k], seq_col[k]);
                exp_win[k]  = in_win(seq_show[k], seq_row[k], seq_col[k]);
                exp_pat[k]  = int'(tmap[exp_addr[k]]) * 8 + (seq_row[k] - OR0) % 8;
                exp_fe[k]   = (seq_show[k] != 0) && seq_row[k] == 479 && seq_col[k] == 639;
                if (exp_fe[k]) frames_seen++;
            end else begin
                show = 1'b0;
                xc   = '0;
                yc   = '0;
            end
            tick();
            obs_addr[k] = tile_addr;
            obs_pat[k]  = pat_addr;
            obs_tick[k] = tick_o;
            obs_px[k]   = {show_d, r_o, g_o, b_o};
        end
    endtask

    task automatic set_px(input int i, input int s, input int r, input int c);
        seq_show[i] = s;
        seq_row[i]  = r;
        seq_col[i]  = c;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        show = 1'b0;
        rst = 1'b0;
        frames_seen = 0;
    endtask

    task automatic test_reset();
        show = 1'b1; xc = 10'd116; yc = 10'd208;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({r_o, g_o, b_o} !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=0", {r_o, g_o, b_o}); end
        checks++; if (show_d !== 1'b0) begin failures++; $display("FAIL reset_show_d got=%b exp=0", show_d); end
        checks++; if (tile_addr !== 10'd0) begin failures++; $display("FAIL reset_tile_addr got=%0d exp=0", tile_addr); end
        checks++; if (pat_addr !== 11'd0) begin failures++; $display("FAIL reset_pat_addr got=%0d exp=0", pat_addr); end
        checks++; if (tick_o !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick_o); end
        do_reset();
    endtask

    task automatic test_first_pixel();
        set_px(0, 1, 116, 208);
        run_seq(1);
        checks++; if (obs_addr[0] !== 10'd0) begin failures++; $display("FAIL first_tile_addr got=%0d exp=0", obs_addr[0]); end
        checks++; if (obs_pat[2] !== 11'h008) begin failures++; $display("FAIL first_pat_addr got=%h exp=008", obs_pat[2]); end
        checks++; if (obs_px[2][24] !== 1'b0) begin failures++; $display("FAIL first_show_d_early got=%b exp=0", obs_px[2][24]); end
        checks++; if (obs_px[3] !== {1'b1, BLUE}) begin failures++; $display("FAIL first_px got=%h exp=%h", obs_px[3], {1'b1, BLUE}); end
    endtask

    task automatic test_corners();
        set_px(0, 1, 363, 431);
        set_px(1, 1, 123, 431);
        run_seq(2);
        checks++; if (obs_addr[0] !== 10'd867) begin failures++; $display("FAIL last_tile_addr got=%0d exp=867", obs_addr[0]); end
        checks++; if (obs_pat[2] !== {8'h5A, 3'd7}) begin failures++; $display("FAIL last_pat_addr got=%h exp=%h", obs_pat[2], {8'h5A, 3'd7}); end
        checks++; if (obs_px[3] !== {1'b1, WHITE}) begin failures++; $display("FAIL last_px got=%h exp=%h", obs_px[3], {1'b1, WHITE}); end
        checks++; if (obs_addr[1] !== 10'd27) begin failures++; $display("FAIL r123_tile_addr got=%0d exp=27", obs_addr[1]); end
        checks++; if (obs_px[4] !== {1'b1, PEACH}) begin failures++; $display("FAIL r123_px got=%h exp=%h", obs_px[4], {1'b1, PEACH}); end
    endtask

    task automatic test_outside();
        set_px(0, 1, 115, 300);
        set_px(1, 1, 200, 432);
        set_px(2, 0, 200, 300);
        set_px(3, 1, 364, 300);
        set_px(4, 1, 200, 207);
        run_seq(5);
        for (int j = 0; j < 5; j++) begin
            checks++; if (obs_addr[j] !== 10'd0) begin failures++; $display("FAIL outside_addr[%0d] got=%0d exp=0", j, obs_addr[j]); end
            checks++; if (obs_px[j+3] !== {(seq_show[j] != 0), 24'h0}) begin failures++; $display("FAIL outside_px[%0d] got=%h exp=%h", j, obs_px[j+3], {(seq_show[j] != 0), 24'h0}); end
        end
    endtask

    task automatic test_stream();
        for (int j = 0; j < 8; j++) set_px(j, 1, 200, 208 + j);
        run_seq(8);
        checks++; if (obs_px[2][24] !== 1'b0) begin failures++; $display("FAIL stream_pre_show got=%b exp=0", obs_px[2][24]); end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (obs_px[j+3] !== {1'b1, ((j % 2) == 0) ? BLUE : WHITE}) begin
                failures++; $display("FAIL stream_px[%0d] got=%h exp=%h", j, obs_px[j+3], {1'b1, ((j % 2) == 0) ? BLUE : WHITE});
            end
        end
        checks++; if (obs_px[11][24] !== 1'b0) begin failures++; $display("FAIL stream_post_show got=%b exp=0", obs_px[11][24]); end
    endtask

    task automatic test_random();
        int n;
        n = 200;
        for (int j = 0; j < n; j++) begin
            if ($urandom_range(0, 9) < 7) set_px(j, int'($urandom_range(0, 9) != 0), int'($urandom_range(116, 363)), int'($urandom_range(208, 431)));
            else set_px(j, int'($urandom_range(0, 9) != 0), int'($urandom_range(0, 479)), int'($urandom_range(0, 639)));
        end
        run_seq(n);
        for (int j = 0; j < n; j++) begin
            checks++; if (obs_addr[j] !== 10'(exp_addr[j])) begin failures++; $display("FAIL rand_addr[%0d] got=%0d exp=%0d", j, obs_addr[j], exp_addr[j]); end
            checks++; if (obs_px[j+3] !== exp_px[j]) begin failures++; $display("FAIL rand_px[%0d] got=%h exp=%h", j, obs_px[j+3], exp_px[j]); end
            checks++; if (obs_tick[j] !== exp_fe[j]) begin failures++; $display("FAIL rand_tick[%0d] got=%b exp=%b", j, obs_tick[j], exp_fe[j]); end
            if (exp_win[j]) begin
                checks++; if (obs_pat[j+2] !== 11'(exp_pat[j])) begin failures++; $display("FAIL rand_pat[%0d] got=%h exp=%h", j, obs_pat[j+2], exp_pat[j]); end
            end
        end
    endtask

    task automatic test_blink();
        logic [24:0] want;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            set_px(2 * f, 1, 157, 234);
            set_px(2 * f + 1, 1, 479, 639);
        end
        run_seq(12);
        for (int f = 0; f < 6; f++) begin
            want = {1'b1, (((f / 2) % 2) == 0) ? PEACH : 24'h0};
            checks++; if (obs_px[2*f+3] !== want) begin failures++; $display("FAIL blink_px[frame %0d] got=%h exp=%h", f, obs_px[2*f+3], want); end
            checks++; if (obs_tick[2*f] !== 1'b0) begin failures++; $display("FAIL blink_tick_low[%0d] got=%b exp=0", f, obs_tick[2*f]); end
            checks++; if (obs_tick[2*f+1] !== 1'b1) begin failures++; $display("FAIL blink_tick[%0d] got=%b exp=1", f, obs_tick[2*f+1]); end
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        for (int f = 0; f < 3; f++) set_px(f, 1, 479, 639);
        run_seq(3);
        show = 1'b1; xc = 10'd157; yc = 10'd234;
        repeat (5) tick();
        #3;
        rst = 1'b1;
        #1;
        checks++; if ({show_d, r_o, g_o, b_o} !== 25'h0) begin failures++; $display("FAIL midrst_px got=%h exp=0", {show_d, r_o, g_o, b_o}); end
        checks++; if (tile_addr !== 10'd0) begin failures++; $display("FAIL midrst_tile_addr got=%0d exp=0", tile_addr); end
        checks++; if (pat_addr !== 11'd0) begin failures++; $display("FAIL midrst_pat_addr got=%h exp=0", pat_addr); end
        @(negedge clk);
        show = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        frames_seen = 0;
        set_px(0, 1, 157, 234);
        set_px(1, 1, 479, 639);
        set_px(2, 1, 157, 234);
        set_px(3, 1, 479, 639);
        set_px(4, 1, 157, 234);
        run_seq(5);
        checks++; if (obs_px[2] !== 25'h0) begin failures++; $display("FAIL midrst_flush got=%h exp=0", obs_px[2]); end
        checks++; if (obs_px[3] !== {1'b1, PEACH}) begin failures++; $display("FAIL midrst_resume got=%h exp=%h", obs_px[3], {1'b1, PEACH}); end
        checks++; if (obs_px[5] !== {1'b1, PEACH}) begin failures++; $display("FAIL midrst_cnt0 got=%h exp=%h", obs_px[5], {1'b1, PEACH}); end
        checks++; if (obs_px[7] !== {1'b1, 24'h0}) begin failures++; $display("FAIL midrst_toggle got=%h exp=%h", obs_px[7], {1'b1, 24'h0}); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) tmap[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 2048; i++) prom[i] = 16'($urandom_range(0, 65535));
        tmap[0]   = 8'h01; prom[8]   = 16'h0001;
        tmap[867] = 8'h5A; prom[727] = 16'hC000;
        tmap[27]  = 8'h5B; prom[735] = 16'h8000;
        tmap[280] = 8'h22; prom[276] = 16'hDDDD;
        tmap[143] = 8'h14; prom[161] = 16'h0020;
        test_reset();
        test_first_pixel();
        test_corners();
        test_outside();
        test_stream();
        test_random();
        test_blink();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
